// File: rtl/ub_row_feeder.sv
// ub_row_feeder: streams consecutive unified-buffer rows from BRAM into the systolic array with a diagonal lane skew
module ub_row_feeder #(
  parameter int LANES  = 16,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    start_i,
  input  logic [ADDR_W-1:0]       base_addr_i,
  input  logic [ADDR_W:0]         num_rows_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    bram_enb_o,
  output logic [ADDR_W-1:0]       bram_addrb_o,
  input  logic [LANES*DATA_W-1:0] bram_doutb_i,
  output logic [LANES*DATA_W-1:0] out_data_o,
  output logic [LANES-1:0]        out_valid_o
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  localparam logic [ADDR_W:0] MAX_ROWS  = (ADDR_W+1)'(1 << ADDR_W);
  localparam logic [ADDR_W:0] DRAIN_CNT = (ADDR_W+1)'(LANES);
  localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [ADDR_W:0]     n_rows;
  logic                rd_vld_q;
  assign n_rows       = (num_rows_i > MAX_ROWS) ? MAX_ROWS : num_rows_i;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign bram_enb_o   = (state_q == READ);
  assign bram_addrb_o = addr_q;
  // Next state: cnt_q counts remaining issues in READ, then remaining skew-flush cycles in DRAIN
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = (n_rows != '0) ? READ : DONE;
        addr_d  = (n_rows != '0) ? base_addr_i : '0;
        cnt_d   = (n_rows != '0) ? n_rows - ONE : '0;
      end
      READ: begin
        state_d = (cnt_q == '0) ? DRAIN : READ;
        addr_d  = (cnt_q == '0) ? '0 : addr_q + ADDR_W'(1);
        cnt_d   = (cnt_q == '0) ? DRAIN_CNT : cnt_q - ONE;
      end
      DRAIN: begin
        state_d = (cnt_q == '0) ? DONE : DRAIN;
        cnt_d   = (cnt_q == '0) ? '0 : cnt_q - ONE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
  // Control registers; read data is valid the cycle after an issue
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      rd_vld_q <= (state_q == READ);
    end
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [(i+1)*DATA_W-1:0] dly_q;
    logic [i:0]              vld_q;
    // Lane i: capture with zero padding when idle, then i further stages of delay
    always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
        dly_q <= '0;
        vld_q <= '0;
      end else begin
        dly_q <= (dly_q << DATA_W) | ((i+1)*DATA_W)'(rd_vld_q ? bram_doutb_i[i*DATA_W +: DATA_W] : '0);
        vld_q <= (vld_q << 1) | (i+1)'(rd_vld_q);
      end
    end
    assign out_data_o[i*DATA_W +: DATA_W] = dly_q[(i+1)*DATA_W-1 -: DATA_W];
    assign out_valid_o[i]                 = vld_q[i];
  end
endmodule

// File: tb/tb_ub_row_feeder.sv
// tb_ub_row_feeder: directed bench for ub_row_feeder with a byte-pattern BRAM model
module tb_ub_row_feeder;
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start_i = 1'b0;
  logic [7:0]   base_addr_i = '0;
  logic [8:0]   num_rows_i = '0;
  logic         busy_o, done_o, bram_enb_o;
  logic [7:0]   bram_addrb_o;
  logic [127:0] bram_q = '0, noise = '0, bram_doutb;
  logic [127:0] out_data_o;
  logic [15:0]  out_valid_o;
  int           n_cmp = 0, n_bad = 0;

  ub_row_feeder dut (
    .clk_i(clk), .reset_ni(reset_n), .start_i(start_i), .base_addr_i(base_addr_i),
    .num_rows_i(num_rows_i), .busy_o(busy_o), .done_o(done_o), .bram_enb_o(bram_enb_o),
    .bram_addrb_o(bram_addrb_o), .bram_doutb_i(bram_doutb), .out_data_o(out_data_o),
    .out_valid_o(out_valid_o)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] row(input logic [7:0] a);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = a + 8'(i);
    return r;
  endfunction

  // BRAM read port: one-cycle latency, row a holds bytes a+i
  always @(posedge clk) if (bram_enb_o) bram_q <= row(bram_addrb_o);
  assign bram_doutb = bram_q ^ noise;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] base, input logic [8:0] num, input bit noisy);
    int n, last, enb_cnt;
    logic [15:0]  ev;
    logic [127:0] ed;
    logic [7:0]   ea;
    n = (num > 9'd256) ? 256 : int'(num);
    last = (n == 0) ? 1 : n + 18;
    enb_cnt = 0;
    start_i = 1'b1;
    base_addr_i = base;
    num_rows_i = num;
    for (int c = 1; c <= last; c++) begin
      tick();
      start_i = noisy && (c == 2 || c == last - 10 || c == last);
      base_addr_i = 8'hC0;
      num_rows_i = 9'd7;
      ev = '0;
      ed = '0;
      for (int i = 0; i < 16; i++)
        if (c - 3 - i >= 0 && c - 3 - i < n) begin
          ev[i] = 1'b1;
          ed[8*i +: 8] = base + 8'(c - 3);
        end
      ea = base + 8'(c - 1);
      enb_cnt += int'(bram_enb_o);
      chk($sformatf("enb_c%0d", c), bram_enb_o, c <= n);
      chk($sformatf("addr_c%0d", c), bram_addrb_o, (c <= n) ? ea : 8'h00);
      chk($sformatf("busy_c%0d", c), busy_o, 1'b1);
      chk($sformatf("done_c%0d", c), done_o, c == last);
      chk($sformatf("valid_c%0d", c), out_valid_o, ev);
      chk($sformatf("data_c%0d", c), out_data_o, ed);
      if (base == 8'h10 && n == 3 && c == 3) chk("lane0_row0_T3", out_data_o[7:0], 8'h10);
      if (base == 8'h10 && n == 3 && c == 10) begin
        chk("lane5_row2_T10", out_data_o[47:40], 8'h17);
        chk("valid5_T10", out_valid_o[5], 1'b1);
      end
    end
    tick();
    start_i = 1'b0;
    chk("busy_after", busy_o, 1'b0);
    chk("done_after", done_o, 1'b0);
    chk("enb_after", bram_enb_o, 1'b0);
    chk("valid_after", out_valid_o, 16'h0);
    chk("enb_count", 32'(enb_cnt), 32'(n));
  endtask

  initial begin
    // 1: reset with random inputs
    for (int j = 0; j < 3; j++) begin
      start_i = 1'b1;
      base_addr_i = 8'($urandom);
      num_rows_i = 9'($urandom);
      noise = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_enb", bram_enb_o, 1'b0);
    chk("rst_addr", bram_addrb_o, 8'h00);
    chk("rst_data", out_data_o, 128'h0);
    chk("rst_valid", out_valid_o, 16'h0);
    start_i = 1'b0;
    noise = '0;
    reset_n = 1'b1;
    tick();
    chk("rel_busy", busy_o, 1'b0);
    chk("rel_valid", out_valid_o, 16'h0);
    // 2: basic three-row transfer
    xfer(8'h10, 9'd3, 1'b0);
    // 3: address wrap
    xfer(8'hFE, 9'd4, 1'b0);
    // 4: zero rows and saturation
    xfer(8'h33, 9'd0, 1'b0);
    xfer(8'h80, 9'd300, 1'b0);
    // 5: starts while busy ignored, start right after DONE accepted
    xfer(8'h40, 9'd3, 1'b1);
    xfer(8'h10, 9'd3, 1'b0);
    // 6: reset in the middle of READ
    start_i = 1'b1;
    base_addr_i = 8'h20;
    num_rows_i = 9'd5;
    tick();
    start_i = 1'b0;
    tick();
    chk("pre_rst_enb", bram_enb_o, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_enb", bram_enb_o, 1'b0);
    chk("mid_rst_addr", bram_addrb_o, 8'h00);
    chk("mid_rst_valid", out_valid_o, 16'h0);
    chk("mid_rst_data", out_data_o, 128'h0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_busy", busy_o, 1'b0);
    chk("post_rst_valid", out_valid_o, 16'h0);
    xfer(8'h10, 9'd3, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
